// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and counter width shared by the pipeline controller.
package pipe_ctrl_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        PCTL_BOOT  = 2'd0,
        PCTL_RUN   = 2'd1,
        PCTL_STALL = 2'd2,
        PCTL_FLUSH = 2'd3
    } pctl_state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect arbitration for the IF -> ID -> EX front end.
// Redirects are combinational; state, bubble counter and acks are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_HOLD = 2,
    parameter int FLUSH_LEN = 1,
    parameter int ADDR_W    = 32
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_jump_req,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic              o_jump_ack,
    input  logic              i_bus_wait,
    input  logic              i_mdu_busy,
    input  logic              i_irq_req,
    input  logic [ADDR_W-1:0] i_irq_addr,
    output logic              o_irq_ack,
    output logic              o_pc_hold,
    output logic              o_pc_jump_en,
    output logic [ADDR_W-1:0] o_pc_jump_addr,
    output logic              o_if_id_flush
);

    localparam logic [CNT_W-1:0] BOOT_CNT    = CNT_W'(BOOT_HOLD);
    localparam logic [CNT_W-1:0] FLUSH_CNT   = CNT_W'(FLUSH_LEN - 1);
    localparam pctl_state_t      REDIR_STATE = (FLUSH_LEN > 1) ? PCTL_FLUSH : PCTL_RUN;

    pctl_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_jump_ack, r_irq_ack;
    logic [ADDR_W-1:0] r_last_addr;
    logic              w_stall, w_jreq, w_ireq, w_take_jump, w_take_irq, w_redir;

    assign w_stall = i_bus_wait | i_mdu_busy;
    // A request still high during its own ack cycle is the old one, not a new one.
    assign w_jreq = i_jump_req & ~r_jump_ack;
    assign w_ireq = i_irq_req & ~r_irq_ack;
    // Jumps may re-redirect during FLUSH; interrupts wait for a plain RUN cycle.
    assign w_take_jump = (r_state == PCTL_RUN || r_state == PCTL_FLUSH) && !w_stall && w_jreq;
    assign w_take_irq  = (r_state == PCTL_RUN) && !w_stall && !w_jreq && w_ireq;
    assign w_redir     = w_take_jump | w_take_irq;

    assign o_pc_jump_en   = w_redir;
    assign o_pc_jump_addr = w_take_jump ? i_jump_addr : w_take_irq ? i_irq_addr : r_last_addr;
    assign o_pc_hold      = (r_state == PCTL_BOOT) | w_stall;
    assign o_if_id_flush  = (r_state == PCTL_BOOT) | w_redir | ((r_state == PCTL_FLUSH) & ~w_stall);
    assign o_jump_ack     = r_jump_ack;
    assign o_irq_ack      = r_irq_ack;

    always_comb begin
        w_state_nxt = PCTL_RUN;
        w_cnt_nxt   = r_cnt;
        if (r_state == PCTL_BOOT) begin
            w_state_nxt = (r_cnt <= CNT_W'(1)) ? PCTL_RUN : PCTL_BOOT;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
        end else if (w_stall) begin
            w_state_nxt = PCTL_STALL;
        end else if (w_redir) begin
            w_state_nxt = REDIR_STATE;
            w_cnt_nxt   = FLUSH_CNT;
        end else if (r_state == PCTL_FLUSH) begin
            w_state_nxt = (r_cnt <= CNT_W'(1)) ? PCTL_RUN : PCTL_FLUSH;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state     <= PCTL_BOOT;
            r_cnt       <= BOOT_CNT;
            r_jump_ack  <= 1'b0;
            r_irq_ack   <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_jump_ack <= w_take_jump;
            r_irq_ack  <= w_take_irq;
            if (w_redir)
                r_last_addr <= o_pc_jump_addr;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two controllers (FLUSH_LEN 1 and 3) driven in lockstep against a
// cycle-level model built from boot/bubble/stall bookkeeping.
module tb_pipe_ctrl;

    localparam int BH = 2;
    localparam int FL [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jreq = 1'b0, bw = 1'b0, mb = 1'b0, ireq = 1'b0;
    logic [31:0] jaddr = '0, iaddr = '0;

    logic        a_jack, a_iack, a_hold, a_en, a_flush;
    logic [31:0] a_addr;
    logic        b_jack, b_iack, b_hold, b_en, b_flush;
    logic [31:0] b_addr;

    int total = 0;
    int bad = 0;

    int          m_boot [2], m_bub [2], n_boot [2], n_bub [2];
    bit          m_stl [2], m_jack [2], m_iack [2], n_stl [2], n_jack [2], n_iack [2];
    logic [31:0] m_last [2], n_last [2];
    logic        e_hold [2], e_flush [2], e_en [2], e_jack [2], e_iack [2];
    logic [31:0] e_addr [2];

    typedef struct {
        logic        jr;
        logic [31:0] ja;
        logic        bw;
        logic        mb;
        logic        ir;
        logic [31:0] ia;
        logic        hold;
        logic        flush;
        logic        en;
        logic [31:0] addr;
        logic        jack;
        logic        iack;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    pipe_ctrl #(.BOOT_HOLD(BH), .FLUSH_LEN(1), .ADDR_W(32)) u_a (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_jump_req(jreq), .i_jump_addr(jaddr), .o_jump_ack(a_jack),
        .i_bus_wait(bw), .i_mdu_busy(mb),
        .i_irq_req(ireq), .i_irq_addr(iaddr), .o_irq_ack(a_iack),
        .o_pc_hold(a_hold), .o_pc_jump_en(a_en), .o_pc_jump_addr(a_addr),
        .o_if_id_flush(a_flush)
    );

    pipe_ctrl #(.BOOT_HOLD(BH), .FLUSH_LEN(3), .ADDR_W(32)) u_b (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_jump_req(jreq), .i_jump_addr(jaddr), .o_jump_ack(b_jack),
        .i_bus_wait(bw), .i_mdu_busy(mb),
        .i_irq_req(ireq), .i_irq_addr(iaddr), .o_irq_ack(b_iack),
        .o_pc_hold(b_hold), .o_pc_jump_en(b_en), .o_pc_jump_addr(b_addr),
        .o_if_id_flush(b_flush)
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_boot[k] = (BH > 0) ? BH : 1;
            m_bub[k]  = 0;
            m_stl[k]  = 0;
            m_jack[k] = 0;
            m_iack[k] = 0;
            m_last[k] = '0;
        end
    endtask

    // Outputs for the current cycle and the bookkeeping for the next one.
    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit st = bw | mb;
            bit jr = jreq & !m_jack[k];
            bit ir = ireq & !m_iack[k] & (m_bub[k] == 0);
            e_hold[k] = 0; e_flush[k] = 0; e_en[k] = 0; e_addr[k] = m_last[k];
            e_jack[k] = m_jack[k]; e_iack[k] = m_iack[k];
            n_boot[k] = m_boot[k]; n_bub[k] = m_bub[k]; n_stl[k] = 0;
            n_jack[k] = 0; n_iack[k] = 0; n_last[k] = m_last[k];
            if (m_boot[k] > 0) begin
                e_hold[k] = 1; e_flush[k] = 1; n_boot[k] = m_boot[k] - 1;
            end else if (st) begin
                e_hold[k] = 1; n_bub[k] = 0; n_stl[k] = 1;
            end else if (m_stl[k]) begin
                n_bub[k] = 0;
            end else if (jr || ir) begin
                e_en[k] = 1; e_flush[k] = 1;
                e_addr[k] = jr ? jaddr : iaddr;
                n_last[k] = e_addr[k];
                n_bub[k] = FL[k] - 1;
                n_jack[k] = jr; n_iack[k] = !jr;
            end else if (m_bub[k] > 0) begin
                e_flush[k] = 1; n_bub[k] = m_bub[k] - 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check("hold",  k, k ? b_hold  : a_hold,  e_hold[k]);
            check("flush", k, k ? b_flush : a_flush, e_flush[k]);
            check("en",    k, k ? b_en    : a_en,    e_en[k]);
            check("addr",  k, k ? b_addr  : a_addr,  e_addr[k]);
            check("jack",  k, k ? b_jack  : a_jack,  e_jack[k]);
            check("iack",  k, k ? b_iack  : a_iack,  e_iack[k]);
        end
    endtask

    task automatic apply(input logic jr, input logic [31:0] ja, input logic w, input logic m,
                         input logic ir, input logic [31:0] ia);
        jreq = jr; jaddr = ja; bw = w; mb = m; ireq = ir; iaddr = ia;
        #1;
        model_eval();
        compare_all();
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            m_boot[k] = n_boot[k]; m_bub[k] = n_bub[k]; m_stl[k] = n_stl[k];
            m_jack[k] = n_jack[k]; m_iack[k] = n_iack[k]; m_last[k] = n_last[k];
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        model_reset();
        #1;
        model_eval();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl = '{
            '{0, 0,      0, 0, 0, 0,     1, 1, 0, 0,      0, 0},
            '{0, 0,      0, 0, 0, 0,     1, 1, 0, 0,      0, 0},
            '{0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      0, 0},
            '{1, 'h100,  0, 0, 0, 0,     0, 1, 1, 'h100,  0, 0},
            '{0, 0,      0, 0, 0, 0,     0, 0, 0, 'h100,  1, 0},
            '{0, 0,      0, 0, 0, 0,     0, 0, 0, 'h100,  0, 0},
            '{1, 'h200,  0, 0, 1, 'h40,  0, 1, 1, 'h200,  0, 0},
            '{0, 0,      0, 0, 1, 'h40,  0, 1, 1, 'h40,   1, 0},
            '{0, 0,      0, 0, 1, 'h40,  0, 0, 0, 'h40,   0, 1},
            '{0, 0,      0, 0, 0, 0,     0, 0, 0, 'h40,   0, 0},
            '{1, 'h300,  1, 0, 0, 0,     1, 0, 0, 'h40,   0, 0},
            '{1, 'h300,  1, 0, 0, 0,     1, 0, 0, 'h40,   0, 0},
            '{1, 'h300,  1, 0, 0, 0,     1, 0, 0, 'h40,   0, 0},
            '{1, 'h300,  0, 0, 0, 0,     0, 0, 0, 'h40,   0, 0},
            '{1, 'h300,  0, 0, 0, 0,     0, 1, 1, 'h300,  0, 0},
            '{0, 0,      0, 0, 0, 0,     0, 0, 0, 'h300,  1, 0}
        };
        model_reset();
        @(negedge clk);
        #1;
        check("rst_hold",  0, a_hold, 1);  check("rst_flush", 0, a_flush, 1);
        check("rst_en",    0, a_en, 0);    check("rst_addr",  0, a_addr, 0);
        check("rst_jack",  0, a_jack, 0);  check("rst_iack",  0, a_iack, 0);
        check("rst_hold",  1, b_hold, 1);  check("rst_flush", 1, b_flush, 1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].jr, tbl[i].ja, tbl[i].bw, tbl[i].mb, tbl[i].ir, tbl[i].ia);
            check($sformatf("tbl%0d_hold", i),  0, a_hold,  tbl[i].hold);
            check($sformatf("tbl%0d_flush", i), 0, a_flush, tbl[i].flush);
            check($sformatf("tbl%0d_en", i),    0, a_en,    tbl[i].en);
            check($sformatf("tbl%0d_addr", i),  0, a_addr,  tbl[i].addr);
            check($sformatf("tbl%0d_jack", i),  0, a_jack,  tbl[i].jack);
            check($sformatf("tbl%0d_iack", i),  0, a_iack,  tbl[i].iack);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            tick();
        end
        // mdu_busy in the middle of a 3-bubble flush drops the remaining bubbles
        apply(1, 'h500, 0, 0, 0, 0); check("t6_en", 1, b_en, 1); tick();
        apply(0, 0, 0, 0, 0, 0); check("t6_flush", 1, b_flush, 1); tick();
        apply(0, 0, 0, 1, 0, 0); check("t6_hold", 1, b_hold, 1); check("t6_stflush", 1, b_flush, 0); tick();
        apply(0, 0, 0, 1, 0, 0); check("t6_hold2", 1, b_hold, 1); tick();
        apply(0, 0, 0, 0, 0, 0); check("t6_rel", 1, b_flush, 0); check("t6_relhold", 1, b_hold, 0); tick();
        apply(0, 0, 0, 0, 0, 0); check("t6_run", 1, b_flush, 0); tick();
        // reset asserted during FLUSH, in the ack cycle
        apply(1, 'h600, 0, 0, 0, 0); check("t5_en", 1, b_en, 1); tick();
        apply(0, 0, 0, 0, 0, 0); check("t5_preack", 1, b_jack, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_jack", 1, b_jack, 0);   check("t5_hold", 1, b_hold, 1);
        check("t5_flush", 1, b_flush, 1); check("t5_en", 1, b_en, 0);
        check("t5_addr", 1, b_addr, 0);   check("t5_ajack", 0, a_jack, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0); check("t5_noack", 1, b_jack, 0); tick();
        apply(0, 0, 0, 0, 0, 0); check("t5_noack2", 1, b_jack, 0); tick();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0)
                reset_pulse();
            else begin
                apply($urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2, $urandom);
                tick();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
